fwd_hazard_unit: RTL and testbench
==================================

# fwd_hazard_unit

Parametrised operand-forwarding and load-use hazard unit for the RGBSetMeFree core pipeline, generalising the fixed two-source ExMe/MeWb forwarding logic. It keeps a registered shadow of the destination tags in flight across `NUM_STAGES` post-decode stages. For the instruction in decode it resolves the youngest producer per source register, FL and LR, registers the forward selects so they line up with that instruction in execute, and raises `stall` when a load result would not be ready in time.

## Interface
- `NUM_SRC`, 2: register source operands per instruction.
- `REG_AW`, 5: register index width.
- `NUM_STAGES`, 3: tracked stages (0 = EX, 1 = ME, 2 = WB); must be ≥ 2.
- `LOAD_STAGE`, 2: first stage index whose load result can be forwarded; range 1..`NUM_STAGES`-1.
- Derived `SELW` = `$clog2(NUM_STAGES)`.

- `clk`  in  1  core clock.
- `rst`  in  1  asynchronous, active-high reset.
- `pipe_adv`  in  1  pipeline advances this cycle.
- `flush`  in  1  kill instruction in decode and stage 0.
- `dec_valid`  in  1  decode holds a valid instruction.
- `dec_src`  in  `NUM_SRC*REG_AW`  source indices; source s is at bits [s*REG_AW +: REG_AW].
- `dec_src_use`  in  `NUM_SRC`  source s actually read.
- `dec_rd_en`, `dec_is_load`, `dec_fl_wr`, `dec_lr_wr`  in  1 each  decode instruction attributes.
- `dec_rd`  in  `REG_AW`  destination index.
- `stall`  out  1  hold decode; insert bubble.
- `fwd_sel`  out  `NUM_SRC*SELW`  per-source select for EX.
- `fwd_fl_sel`, `fwd_lr_sel`  out  `SELW` each  FL / LR select for EX.
- `stall_cnt`  out  32  stall performance counter (see Configuration).

## Operation
- Shadow entry k holds {valid, rd_en, rd, is_load, fl_wr, lr_wr}.
- Select value j ≥ 1 means "take the result of stage j". 0 means architectural source (register file, FL, LR).
- **Match:** for each used source s with `dec_src[s]` ≠ 0, find the lowest k with valid & rd_en & rd == `dec_src[s]`.
  - If k+1 ≤ `NUM_STAGES`-1, the candidate select is k+1.
  - Otherwise the producer retires before use; select 0.
  - Register 0 is never forwarded and never stalls.
- **FL/LR:** same youngest-writer search using fl_wr / lr_wr. No register-index compare.
- **Load-use:** `stall` = `dec_valid` & ~`flush` & (any used source whose youngest match has is_load & k+1 < `LOAD_STAGE`). Computed combinationally.
- **Advance** (`pipe_adv`=1, `flush`=0):
  - Entries shift k → k+1; the last entry is dropped.
  - If ~`stall` & `dec_valid`: entry 0 is loaded from `dec_*`, and the selects are registered from the candidates.
  - Otherwise: entry 0 becomes a bubble (valid=0), and all selects register 0.
- **Hold** (`pipe_adv`=0): entries and selects hold; `stall` is still evaluated.
- **Flush** (`pipe_adv` don't-care): entry 0 is invalidated and selects register 0. The decode instruction is not captured. Entries 1.. shift only if `pipe_adv`. Flush overrides stall.
- **Reset values:** all entries invalid; `fwd_sel`, `fwd_fl_sel`, `fwd_lr_sel` = 0; `stall` = 0; `stall_cnt` = 0.

## Timing
- Select latency is 1 cycle. Candidates computed in cycle t (decode) appear on the `fwd_*` outputs in t+1, aligned with the instruction in EX.
- `stall` is combinational from the `dec_*` inputs and registered state. It has no input-to-output path through `pipe_adv`.
- A load-use stall lasts exactly `LOAD_STAGE` − (k+1) advancing cycles. Non-advancing cycles extend it.
- Simultaneous `rst` and any input: reset wins, asynchronously.
- Reset mid-stall drops `stall` immediately.

## Configuration
- `FWD_STALL_CNT_EN` defined:
  - `stall_cnt` increments on every cycle with `stall` & `pipe_adv`.
  - It saturates at 0xFFFF_FFFF.
  - It is cleared only by `rst`.
- `FWD_STALL_CNT_EN` undefined: the counter is not built and `stall_cnt` is tied to 0.

## Structure
- Shared package `fwd_pkg`:
  - `fwd_entry_t` struct.
  - Default parameter constants.
  - Function `fwd_selw(n)`.
- Sub-module `fwd_src_match`: combinational youngest-match priority encoder, instantiated `NUM_SRC`+2 times (sources, FL, LR). It outputs the hit flag, stage index and is_load.
- The top level holds the shadow shift register, registered selects, stall logic and optional counter.

## Test plan
1. ALU I1 writes r5, next cycle I2 reads r5 as src0 → in I2's EX cycle, `fwd_sel[0]`=1 and `stall`=0.
2. I1 writes r5, one bubble, then I2 reads r5 → `fwd_sel[0]`=2. With two bubbles → `fwd_sel[0]`=0.
3. Load to r7, next cycle add reads r7 (`LOAD_STAGE`=2) → `stall`=1 for exactly one advancing cycle. Then `fwd_sel`=2 and, with the macro on, `stall_cnt`=1.
4. I1 and I2 both write r3, I3 reads r3 as src1 → `fwd_sel[1]`=1 (youngest wins). I1 writes FL, I2 writes LR, I3 reads both → `fwd_fl_sel`=2, `fwd_lr_sel`=1.
5. Source r0 with an in-flight writer to r0, and a used=0 source matching a load → no stall, selects 0.
6. Assert `rst` during a load-use stall → `stall`=0 and all selects 0 immediately, shadow cleared; repeat with `flush` instead → stall drops and the EX selects register 0.

Source files
------------

// File: rtl/fwd_pkg.sv
// fwd_pkg: shared shadow-entry type, default parameters and select-width helper for fwd_hazard_unit
package fwd_pkg;
  localparam int FWD_NUM_SRC    = 2;
  localparam int FWD_REG_AW     = 5;
  localparam int FWD_NUM_STAGES = 3;
  localparam int FWD_LOAD_STAGE = 2;
  // Shadow entries carry the destination index at this fixed width; REG_AW must not exceed it.
  localparam int FWD_RD_MAXW    = 16;

  localparam logic [1:0] FWD_MODE_REG = 2'd0;
  localparam logic [1:0] FWD_MODE_FL  = 2'd1;
  localparam logic [1:0] FWD_MODE_LR  = 2'd2;

  typedef struct packed {
    logic                   valid;
    logic                   rd_en;
    logic [FWD_RD_MAXW-1:0] rd;
    logic                   is_load;
    logic                   fl_wr;
    logic                   lr_wr;
  } fwd_entry_t;

  function automatic int fwd_selw(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/fwd_src_match.sv
// fwd_src_match: youngest-producer priority encoder over the in-flight shadow entries
module fwd_src_match import fwd_pkg::*; #(
  parameter int         NUM_STAGES = FWD_NUM_STAGES,
  parameter logic [1:0] MODE       = FWD_MODE_REG,
  localparam int        SELW       = fwd_selw(NUM_STAGES)
) (
  input  fwd_entry_t             i_ent [NUM_STAGES],
  input  logic [FWD_RD_MAXW-1:0] i_key,
  input  logic                   i_en,
  output logic                   o_hit,
  output logic [SELW-1:0]        o_idx,
  output logic                   o_is_load
);
  logic [NUM_STAGES-1:0] w_m;

  genvar k;
  for (k = 0; k < NUM_STAGES; k++) begin : g_m
    assign w_m[k] = i_ent[k].valid && ((MODE == FWD_MODE_REG) ? (i_ent[k].rd_en && i_ent[k].rd == i_key) :
                                       (MODE == FWD_MODE_FL)  ? i_ent[k].fl_wr : i_ent[k].lr_wr);
  end

  // Scan oldest to youngest so the lowest matching stage wins.
  always_comb begin
    o_hit     = 1'b0;
    o_idx     = '0;
    o_is_load = 1'b0;
    for (int s = NUM_STAGES - 1; s >= 0; s--)
      if (i_en && w_m[s]) begin
        o_hit     = 1'b1;
        o_idx     = SELW'(s);
        o_is_load = i_ent[s].is_load;
      end
  end
endmodule

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: operand forwarding selects and load-use stall; optional stall counter under FWD_STALL_CNT_EN
module fwd_hazard_unit import fwd_pkg::*; #(
  parameter int  NUM_SRC    = FWD_NUM_SRC,
  parameter int  REG_AW     = FWD_REG_AW,
  parameter int  NUM_STAGES = FWD_NUM_STAGES,
  parameter int  LOAD_STAGE = FWD_LOAD_STAGE,
  localparam int SELW       = fwd_selw(NUM_STAGES)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      pipe_adv,
  input  logic                      flush,
  input  logic                      dec_valid,
  input  logic [NUM_SRC*REG_AW-1:0] dec_src,
  input  logic [NUM_SRC-1:0]        dec_src_use,
  input  logic                      dec_rd_en,
  input  logic                      dec_is_load,
  input  logic                      dec_fl_wr,
  input  logic                      dec_lr_wr,
  input  logic [REG_AW-1:0]         dec_rd,
  output logic                      stall,
  output logic [NUM_SRC*SELW-1:0]   fwd_sel,
  output logic [SELW-1:0]           fwd_fl_sel,
  output logic [SELW-1:0]           fwd_lr_sel,
  output logic [31:0]               stall_cnt
);
  // Match slots: sources first, then FL, then LR.
  localparam int NM = NUM_SRC + 2;

  fwd_entry_t               r_sh [NUM_STAGES];
  logic [NUM_SRC*SELW-1:0]  r_sel;
  logic [SELW-1:0]          r_fl;
  logic [SELW-1:0]          r_lr;

  logic [FWD_RD_MAXW-1:0]   w_key  [NM];
  logic [NM-1:0]            w_en;
  logic [NM-1:0]            w_hit;
  logic [SELW-1:0]          w_idx  [NM];
  logic [NM-1:0]            w_ld;
  logic [SELW-1:0]          w_cand [NM];
  logic [NUM_SRC*SELW-1:0]  w_sel_n;
  logic                     w_lu;
  logic                     w_cap;
  fwd_entry_t               w_new;

  genvar g;
  for (g = 0; g < NM; g++) begin : g_m
    if (g < NUM_SRC) begin : g_s
      assign w_key[g] = FWD_RD_MAXW'(dec_src[g*REG_AW +: REG_AW]);
      assign w_en[g]  = dec_src_use[g] && (dec_src[g*REG_AW +: REG_AW] != '0);
      assign w_sel_n[g*SELW +: SELW] = w_cand[g];
    end else begin : g_f
      assign w_key[g] = '0;
      assign w_en[g]  = 1'b1;
    end
    fwd_src_match #(
      .NUM_STAGES(NUM_STAGES),
      .MODE((g < NUM_SRC) ? FWD_MODE_REG : (g == NUM_SRC) ? FWD_MODE_FL : FWD_MODE_LR)
    ) u_match (
      .i_ent    (r_sh),
      .i_key    (w_key[g]),
      .i_en     (w_en[g]),
      .o_hit    (w_hit[g]),
      .o_idx    (w_idx[g]),
      .o_is_load(w_ld[g])
    );
    // A producer in the last tracked stage has retired by EX time; read the architectural copy.
    assign w_cand[g] = (w_hit[g] && int'(w_idx[g]) < NUM_STAGES - 1) ? SELW'(int'(w_idx[g]) + 1) : '0;
  end

  // Load-use: a used source whose youngest producer is a load not yet at a forwardable stage.
  always_comb begin
    w_lu = 1'b0;
    for (int s = 0; s < NM; s++)
      if (s < NUM_SRC && w_hit[s] && w_ld[s] && int'(w_idx[s]) + 1 < LOAD_STAGE)
        w_lu = 1'b1;
  end

  assign stall = dec_valid && !flush && w_lu;
  assign w_cap = dec_valid && !flush && !w_lu;
  assign w_new = '{valid: 1'b1, rd_en: dec_rd_en, rd: FWD_RD_MAXW'(dec_rd),
                   is_load: dec_is_load, fl_wr: dec_fl_wr, lr_wr: dec_lr_wr};

  // Shadow shift register and EX-aligned forward selects.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_STAGES; k++) r_sh[k] <= '0;
      r_sel <= '0;
      r_fl  <= '0;
      r_lr  <= '0;
    end else begin
      if (pipe_adv)
        for (int k = 1; k < NUM_STAGES; k++) r_sh[k] <= r_sh[k-1];
      if (pipe_adv || flush) begin
        r_sh[0] <= w_cap ? w_new : '0;
        r_sel   <= w_cap ? w_sel_n : '0;
        r_fl    <= w_cap ? w_cand[NUM_SRC] : '0;
        r_lr    <= w_cap ? w_cand[NUM_SRC+1] : '0;
      end
    end
  end

  assign fwd_sel    = r_sel;
  assign fwd_fl_sel = r_fl;
  assign fwd_lr_sel = r_lr;

`ifdef FWD_STALL_CNT_EN
  logic [31:0] r_cnt;

  // Saturating count of advancing cycles spent stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_cnt <= '0;
    else if (stall && pipe_adv && r_cnt != '1) r_cnt <= r_cnt + 32'd1;
  end

  assign stall_cnt = r_cnt;
`else
  assign stall_cnt = '0;
`endif
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb_fwd_hazard_unit: directed checks of forwarding selects, load-use stall, reset and flush
module tb_fwd_hazard_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_adv;
  logic        flush;
  logic        dec_valid;
  logic [9:0]  dec_src;
  logic [1:0]  dec_src_use;
  logic        dec_rd_en;
  logic        dec_is_load;
  logic        dec_fl_wr;
  logic        dec_lr_wr;
  logic [4:0]  dec_rd;
  logic        stall;
  logic [3:0]  fwd_sel;
  logic [1:0]  fwd_fl_sel;
  logic [1:0]  fwd_lr_sel;
  logic [31:0] stall_cnt;
  int          tests = 0;
  int          fails = 0;

`ifdef FWD_STALL_CNT_EN
  localparam logic [31:0] CNT_AFTER_T3 = 32'd1;
`else
  localparam logic [31:0] CNT_AFTER_T3 = 32'd0;
`endif

  fwd_hazard_unit dut (
    .clk(clk), .rst(rst), .pipe_adv(pipe_adv), .flush(flush), .dec_valid(dec_valid),
    .dec_src(dec_src), .dec_src_use(dec_src_use), .dec_rd_en(dec_rd_en),
    .dec_is_load(dec_is_load), .dec_fl_wr(dec_fl_wr), .dec_lr_wr(dec_lr_wr),
    .dec_rd(dec_rd), .stall(stall), .fwd_sel(fwd_sel), .fwd_fl_sel(fwd_fl_sel),
    .fwd_lr_sel(fwd_lr_sel), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic put(input logic v, input logic [4:0] s0, input logic [4:0] s1, input logic [1:0] u,
                     input logic rde, input logic [4:0] rd, input logic ld, input logic fl, input logic lr);
    dec_valid   = v;
    dec_src     = {s1, s0};
    dec_src_use = u;
    dec_rd_en   = rde;
    dec_rd      = rd;
    dec_is_load = ld;
    dec_fl_wr   = fl;
    dec_lr_wr   = lr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    put(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) step();
  endtask

  initial begin
    rst = 1'b1;
    pipe_adv = 1'b1;
    flush = 1'b0;
    put(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) step();
    chk("rst_stall", stall, 0);
    chk("rst_sel", fwd_sel, 0);
    chk("rst_fl", fwd_fl_sel, 0);
    chk("rst_lr", fwd_lr_sel, 0);
    chk("rst_cnt", stall_cnt, 0);
    rst = 1'b0;
    step();

    // Back-to-back ALU dependency.
    put(1, 0, 0, 2'b00, 1, 5, 0, 0, 0); step();
    put(1, 5, 0, 2'b01, 0, 0, 0, 0, 0); #1;
    chk("t1_stall", stall, 0);
    step();
    chk("t1_sel", fwd_sel, 4'h1);
    drain();

    // One bubble between producer and consumer.
    put(1, 0, 0, 2'b00, 1, 5, 0, 0, 0); step();
    put(0, 0, 0, 2'b00, 0, 0, 0, 0, 0); step();
    put(1, 5, 0, 2'b01, 0, 0, 0, 0, 0); step();
    chk("t2_sel_wb", fwd_sel, 4'h2);
    drain();

    // Two bubbles: producer has retired.
    put(1, 0, 0, 2'b00, 1, 5, 0, 0, 0); step();
    put(0, 0, 0, 2'b00, 0, 0, 0, 0, 0); step();
    step();
    put(1, 5, 0, 2'b01, 0, 0, 0, 0, 0); step();
    chk("t2_sel_rf", fwd_sel, 4'h0);
    drain();

    // Load-use, with a held cycle that must not shorten the stall.
    put(1, 0, 0, 2'b00, 1, 7, 1, 0, 0); step();
    put(1, 7, 0, 2'b01, 1, 8, 0, 0, 0); #1;
    chk("t3_stall", stall, 1);
    pipe_adv = 1'b0;
    step();
    chk("t3_hold_stall", stall, 1);
    chk("t3_hold_sel", fwd_sel, 4'h0);
    pipe_adv = 1'b1;
    step();
    chk("t3_stall_end", stall, 0);
    chk("t3_bubble_sel", fwd_sel, 4'h0);
    step();
    chk("t3_sel", fwd_sel, 4'h2);
    chk("t3_cnt", stall_cnt, CNT_AFTER_T3);
    drain();

    // Youngest writer wins on src1.
    put(1, 0, 0, 2'b00, 1, 3, 0, 0, 0); step();
    put(1, 0, 0, 2'b00, 1, 3, 0, 0, 0); step();
    put(1, 0, 3, 2'b10, 0, 0, 0, 0, 0); step();
    chk("t4_youngest", fwd_sel, 4'h4);
    drain();

    // FL and LR writers in different stages.
    put(1, 0, 0, 2'b00, 0, 0, 0, 1, 0); step();
    put(1, 0, 0, 2'b00, 0, 0, 0, 0, 1); step();
    put(1, 0, 0, 2'b00, 0, 0, 0, 0, 0); step();
    chk("t4_fl", fwd_fl_sel, 2);
    chk("t4_lr", fwd_lr_sel, 1);
    drain();

    // r0 never forwards; unused source ignores a matching load.
    put(1, 0, 0, 2'b00, 1, 0, 0, 0, 0); step();
    put(1, 0, 0, 2'b00, 1, 9, 1, 0, 0); step();
    put(1, 0, 9, 2'b01, 0, 0, 0, 0, 0); #1;
    chk("t5_stall", stall, 0);
    step();
    chk("t5_sel", fwd_sel, 4'h0);
    drain();

    // Reset in the middle of a load-use stall.
    put(1, 0, 0, 2'b00, 1, 4, 0, 0, 0); step();
    put(1, 4, 0, 2'b01, 1, 7, 1, 0, 0); step();
    chk("t6_pre_sel", fwd_sel, 4'h1);
    put(1, 7, 0, 2'b01, 1, 8, 0, 0, 0); #1;
    chk("t6_pre_stall", stall, 1);
    rst = 1'b1;
    #1;
    chk("t6_rst_stall", stall, 0);
    chk("t6_rst_sel", fwd_sel, 4'h0);
    chk("t6_rst_cnt", stall_cnt, 0);
    rst = 1'b0;
    #1;
    chk("t6_cleared_stall", stall, 0);
    step();
    chk("t6_cleared_sel", fwd_sel, 4'h0);
    drain();

    // Flush in the middle of a load-use stall.
    put(1, 0, 0, 2'b00, 1, 4, 0, 0, 0); step();
    put(1, 4, 0, 2'b01, 1, 7, 1, 0, 0); step();
    put(1, 7, 0, 2'b01, 1, 8, 0, 0, 0); #1;
    chk("t6f_pre_stall", stall, 1);
    flush = 1'b1;
    #1;
    chk("t6f_stall", stall, 0);
    step();
    chk("t6f_sel", fwd_sel, 4'h0);
    flush = 1'b0;
    #1;
    chk("t6f_after_stall", stall, 0);
    step();
    chk("t6f_after_sel", fwd_sel, 4'h2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
